// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE row sequencer: FSM states,
// weight-register addresses and the default output FIFO depth.
package pe_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] CFG_W1 = 2'd0;
    localparam logic [1:0] CFG_W2 = 2'd1;
    localparam logic [1:0] CFG_W3 = 2'd2;

    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/pe_out_fifo.sv
// Synchronous FIFO for PE results: 8-bit data plus an end-of-row flag,
// with fall-through head and occupancy reporting.
module pe_out_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic             head_last,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array is cleared on reset too, so nothing stale
    // from an aborted row can ever reappear at the head.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr][7:0];
    assign head_last = mem[rd_ptr][8];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/pe_row_sequencer.sv
// Streams one image row through the 3-tap PE: builds the sliding window,
// issues it under a credit limit and buffers results in pe_out_fifo.
module pe_row_sequencer
    import pe_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic [LEN_W-1:0] row_len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [7:0]       pe_w1,
    output logic [7:0]       pe_w2,
    output logic [7:0]       pe_w3,
    output logic [23:0]      pe_p,
    output logic             pe_p_valid,
    input  logic [7:0]       pe_o,
    input  logic             pe_o_valid,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t           state_q, state_d;
    logic [7:0]       w1, w2, w3;
    logic [LEN_W-1:0] len, in_cnt, out_cnt;
    logic [CNT_W-1:0] credits, fifo_count;
    logic [15:0]      win;
    logic             accept, issue, pop;
    logic             start_ok, short_start, final_pop;
    logic             fifo_last_in, fifo_head_last, fifo_full, fifo_empty;
    logic [7:0]       fifo_head_data;

    assign accept   = s_tvalid && s_tready;
    assign issue    = accept && (in_cnt >= LEN_W'(2));
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_head_data;
    assign m_tlast  = m_tvalid && fifo_head_last;
    assign pop      = m_tvalid && m_tready;
    assign pe_w1    = w1;
    assign pe_w2    = w2;
    assign pe_w3    = w3;

    // Index of the entry being pushed = results already popped + results still queued.
    assign fifo_last_in = (out_cnt + LEN_W'(fifo_count)) == (len - LEN_W'(3));

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        s_tready    = 1'b0;
        start_ok    = 1'b0;
        short_start = 1'b0;
        final_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && row_len >= LEN_W'(3)) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                end else if (start) begin
                    short_start = 1'b1;
                end
            end
            RUN: begin
                s_tready = (in_cnt < len) &&
                           ((in_cnt < LEN_W'(2)) || (credits < CNT_W'(FIFO_DEPTH)));
                if (s_tvalid && s_tready && in_cnt == len - LEN_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && m_tlast) begin
                    final_pop = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w1 <= '0; w2 <= '0; w3 <= '0;
            len        <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            credits    <= '0;
            win        <= '0;
            pe_p       <= '0;
            pe_p_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= short_start || final_pop;
            pe_p_valid <= 1'b0;
            if (state_q == IDLE && cfg_we) begin
                case (cfg_addr)
                    CFG_W1:  w1 <= cfg_wdata;
                    CFG_W2:  w2 <= cfg_wdata;
                    CFG_W3:  w3 <= cfg_wdata;
                    default: ;
                endcase
            end
            if (start_ok) begin
                len     <= row_len;
                in_cnt  <= '0;
                out_cnt <= '0;
                busy    <= 1'b1;
            end
            if (accept) begin
                win    <= {win[7:0], s_tdata};
                in_cnt <= in_cnt + LEN_W'(1);
            end
            if (issue) begin
                pe_p       <= {win, s_tdata};
                pe_p_valid <= 1'b1;
            end
            if (pop) out_cnt <= out_cnt + LEN_W'(1);
            case ({issue, pop})
                2'b10:   credits <= credits + CNT_W'(1);
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
            if (final_pop) busy <= 1'b0;
        end
    end

    pe_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (pe_o_valid),
        .push_data (pe_o),
        .push_last (fifo_last_in),
        .pop       (pop),
        .head_data (fifo_head_data),
        .head_last (fifo_head_last),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(pe_o_valid && fifo_full));
    a_credit_cap:  assert property (@(posedge clk) disable iff (!rstn) credits <= CNT_W'(FIFO_DEPTH));

endmodule

// File: doc/pe_row_sequencer.md
# pe_row_sequencer

Sequences one image row through the 3-tap `pe` datapath. It accepts an 8-bit pixel stream from the DMA side and holds the three tap weights. It builds the sliding 3-pixel window, issues it to the PE, and buffers the PE results in a small output FIFO. A credit scheme covers the PE's fixed 2-cycle, non-stallable pipeline, so results are never dropped under output backpressure.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; also the credit limit. Must be ≥ 3 for full throughput.
- `LEN_W`, 12: width of the row-length field.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low; clock `clk`.
- `cfg_we` in 1: weight write strobe.
- `cfg_addr` in 2: 0 → w1, 1 → w2, 2 → w3, 3 → ignored.
- `cfg_wdata` in 8: signed weight value.
- `row_len` in LEN_W: pixels in the row; sampled on an accepted start.
- `start` in 1: begin a row job.
- `busy` out 1: a job is in progress.
- `done` out 1: one-cycle pulse at job end.
- `s_tdata` in 8, `s_tvalid` in 1, `s_tready` out 1: pixel input stream.
- `pe_w1`, `pe_w2`, `pe_w3` out 8 each: weights driven to the PE.
- `pe_p` out 24: PE window, {oldest, middle, newest}.
- `pe_p_valid` out 1: PE window valid.
- `pe_o` in 8, `pe_o_valid` in 1: PE result.
- `m_tdata` out 8, `m_tvalid` out 1, `m_tready` in 1, `m_tlast` out 1: result output stream.

## Operation
- **Reset:** every output and internal register goes to 0. The FIFO and credit counter are emptied and the state becomes IDLE.
- **Weights:**
  - A `cfg_we` write is taken only while IDLE.
  - Writes while busy are ignored.
  - `pe_w*` are driven directly from the weight registers, so they are stable for the whole job.
- **IDLE:**
  - `start` with `row_len` ≥ 3: latch `len`, clear the counters, set `busy`, go to RUN.
  - `start` with `row_len` < 3: pulse `done` on the next cycle, produce no output, stay in IDLE.
- **RUN:**
  - `s_tready` is 1 when `in_cnt` < `len` and either `in_cnt` < 2 or `credits` < FIFO_DEPTH.
  - On accept: `win <= {win[15:0], s_tdata}` and `in_cnt++`.
  - If the accepted pixel has index ≥ 2: register `pe_p <= {win[15:0], s_tdata}`, set `pe_p_valid <= 1`, and `credits++`. Otherwise `pe_p_valid <= 0`.
  - When `in_cnt` reaches `len`, go to DRAIN.
- **DRAIN:**
  - `s_tready` is 0.
  - The final pop (`m_tvalid && m_tready && m_tlast`) clears `busy`, pulses `done` on the next cycle, and returns to IDLE.
- **FIFO:**
  - Push when `pe_o_valid`; pop on `m_tvalid && m_tready`.
  - Push and pop in the same cycle are both allowed.
  - Credits (outstanding = in PE + in FIFO) guarantee no overflow. Push-while-full is an assertion failure.
- **Credits:**
  - +1 on issue, −1 on pop; an issue and a pop in the same cycle leave the count unchanged.
  - The count never exceeds FIFO_DEPTH.
- **Output:**
  - `out_cnt` counts pops.
  - `m_tlast` is 1 on the entry with index `len−3`.
  - `len − 2` results are produced per job.
- **Other rules:**
  - `start` while busy is ignored.
  - `s_tvalid` while IDLE is not accepted (`s_tready` is 0).
  - A reset mid-row discards all data in flight; no `done` is issued.

## Timing
- An accept in cycle c gives `pe_p_valid` in c+1, `pe_o_valid` in c+2, and `m_tvalid` in c+3 with the result.
- With `m_tready` held at 1, accepts run at 1 pixel/cycle; each credit is held for 3 cycles.
- With `m_tready` at 0 from the start, exactly 2 + FIFO_DEPTH pixels are accepted before `s_tready` falls.
- `done` is asserted in the cycle after the final pop. `busy` is 0 from that same cycle.
- `m_tdata`, `m_tvalid` and `m_tlast` come from the FIFO head and hold stable while `m_tready` = 0.

## Structure
- **Package `pe_seq_pkg`:**
  - State enum: IDLE, RUN, DRAIN.
  - Address constants: CFG_W1 = 0, CFG_W2 = 1, CFG_W3 = 2.
  - Default FIFO_DEPTH.
- **Sub-module `pe_out_fifo`:** synchronous FIFO with 8-bit data plus a 1-bit last flag, reporting count, full and empty.
- **Top:** FSM, window register, counters and credit counter.
- **Bench:** instantiates the existing `pe` together with `pe_row_sequencer`.

## Test plan
- **Basic row:** weights 1,1,1; `row_len` = 5; pixels 1,2,3,4,5; `m_tready` = 1.
  - Outputs 6, 9, 12, with `m_tlast` on 12.
  - First `m_tvalid` 3 cycles after the third pixel is accepted.
  - `done` one cycle after the pop of 12.
- **Saturation:** weights 10,10,10; pixels 10,10,10 (sum 300).
  - Output 0x7F.
- **Backpressure:** `m_tready` = 0; `row_len` = 10.
  - `s_tready` falls after 6 accepts.
  - Raising `m_tready` then yields all 8 results, in order, with no loss.
- **Short row:** `row_len` = 2 on `start`.
  - `done` on the next cycle, no `m_tvalid`, `busy` never 1.
- **Config lock:** write w1 = 5 during RUN.
  - `pe_w1` unchanged for the job.
  - A write after `done` takes effect.
- **Reset mid-row:** assert `rstn` = 0 after 4 pixels.
  - Next cycle: `busy`, `m_tvalid`, `pe_p_valid` and `s_tready` are all 0 and the FIFO is empty.
  - A new job runs correctly.
